// File: rtl/fft32_in_framer_if.sv
// Stream bundle between a sample source and fft32_in_framer.
// FLUSH exists only when FRAMER_FLUSH_EN is defined.
interface fft32_in_framer_if #(
  parameter int nb = 16
);
  logic [nb-1:0] IN_DR;
  logic [nb-1:0] IN_DI;
  logic          IN_VLD;
  logic          IN_RDY;
  logic          START;
  logic [nb-1:0] DR;
  logic [nb-1:0] DI;
  logic          BUSY;
`ifdef FRAMER_FLUSH_EN
  logic          FLUSH;

  modport master (
    output IN_DR, IN_DI, IN_VLD, FLUSH,
    input  IN_RDY, START, DR, DI, BUSY
  );
  modport slave (
    input  IN_DR, IN_DI, IN_VLD, FLUSH,
    output IN_RDY, START, DR, DI, BUSY
  );
`else
  modport master (
    output IN_DR, IN_DI, IN_VLD,
    input  IN_RDY, START, DR, DI, BUSY
  );
  modport slave (
    input  IN_DR, IN_DI, IN_VLD,
    output IN_RDY, START, DR, DI, BUSY
  );
`endif
endinterface

// File: rtl/fft32_in_framer.sv
// Ping-pong input framer for FFT32: packs a valid/ready stream into 32-sample frames,
// emitting START then 32 back-to-back samples. FRAMER_FLUSH_EN enables zero-pad flushing.
module fft32_in_framer #(
  parameter int nb  = 16,
  parameter int GAP = 0
) (
  input  logic               CLK,
  input  logic               RST,
  fft32_in_framer_if.slave   bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] STRT = 2'd1;
  localparam logic [1:0] STRM = 2'd2;
  localparam logic [1:0] WAIT = 2'd3;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  logic [nb-1:0] bank_re [0:63];
  logic [nb-1:0] bank_im [0:63];

  logic [1:0]    full_q, full_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [4:0]    wr_addr_q, wr_addr_d;
  logic [4:0]    rd_addr_q, rd_addr_d;
  logic [1:0]    state_q, state_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [nb-1:0] dr_q, dr_d;
  logic [nb-1:0] di_q, di_d;
  logic          rdy_en_q;
`ifdef FRAMER_FLUSH_EN
  logic          flush_q, flush_d;
`endif

  logic          in_rdy;
  logic          accept;
  logic          wr_en;
  logic [5:0]    wr_idx;
  logic [nb-1:0] wr_re, wr_im;
  logic          rd_release;
  logic          rd_fetch;
  logic [4:0]    fetch_addr;

  // rdy_en_q keeps IN_RDY low through reset and until the first edge after release
`ifdef FRAMER_FLUSH_EN
  assign in_rdy = rdy_en_q & ~full_q[wr_bank_q] & ~flush_q;
`else
  assign in_rdy = rdy_en_q & ~full_q[wr_bank_q];
`endif
  assign accept = bus.IN_VLD & in_rdy;
  assign wr_idx = {wr_bank_q, wr_addr_q};

  assign bus.IN_RDY = in_rdy;
  assign bus.START  = (state_q == STRT);
  assign bus.BUSY   = (state_q == STRT) || (state_q == STRM);
  assign bus.DR     = dr_q;
  assign bus.DI     = di_q;

  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    rd_bank_d  = rd_bank_q;
    gap_cnt_d  = gap_cnt_q;
    rd_release = 1'b0;
    rd_fetch   = 1'b0;
    fetch_addr = 5'd0;
    dr_d       = '0;
    di_d       = '0;
    // The output register is loaded one cycle ahead, so the entry shown in STRM is rd_addr_q
    case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d   = STRT;
          rd_addr_d = 5'd0;
        end
      end
      STRT: begin
        state_d    = STRM;
        rd_fetch   = 1'b1;
        fetch_addr = 5'd0;
      end
      STRM: begin
        if (rd_addr_q == 5'd31) begin
          rd_release = 1'b1;
          rd_bank_d  = ~rd_bank_q;
          if (GAP > 0) begin
            state_d   = WAIT;
            gap_cnt_d = GW'(GAP - 1);
          end else begin
            state_d = IDLE;
          end
        end else begin
          rd_addr_d  = rd_addr_q + 5'd1;
          rd_fetch   = 1'b1;
          fetch_addr = rd_addr_q + 5'd1;
        end
      end
      default: begin
        if (gap_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
    endcase
    if (rd_fetch) begin
      dr_d = bank_re[{rd_bank_q, fetch_addr}];
      di_d = bank_im[{rd_bank_q, fetch_addr}];
    end
  end

  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    wr_addr_d = wr_addr_q;
    wr_en     = accept;
    wr_re     = bus.IN_DR;
    wr_im     = bus.IN_DI;
`ifdef FRAMER_FLUSH_EN
    flush_d   = flush_q;
    if (flush_q) begin
      wr_en = 1'b1;
      wr_re = '0;
      wr_im = '0;
    end
`endif
    if (wr_en) begin
      wr_addr_d = wr_addr_q + 5'd1;
      if (wr_addr_q == 5'd31) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
`ifdef FRAMER_FLUSH_EN
        flush_d           = 1'b0;
`endif
      end
    end
`ifdef FRAMER_FLUSH_EN
    // A sample accepted alongside FLUSH is counted before deciding whether padding is needed
    if (!flush_q && bus.FLUSH && (wr_addr_d != 5'd0)) begin
      flush_d = 1'b1;
    end
`endif
    // The reader only ever releases the bank the writer is not filling
    if (rd_release) begin
      full_d[rd_bank_q] = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      full_q    <= 2'b00;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_addr_q <= 5'd0;
      rd_addr_q <= 5'd0;
      state_q   <= IDLE;
      gap_cnt_q <= '0;
      dr_q      <= '0;
      di_q      <= '0;
      rdy_en_q  <= 1'b0;
`ifdef FRAMER_FLUSH_EN
      flush_q   <= 1'b0;
`endif
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      dr_q      <= dr_d;
      di_q      <= di_d;
      rdy_en_q  <= 1'b1;
`ifdef FRAMER_FLUSH_EN
      flush_q   <= flush_d;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      bank_re[wr_idx] <= wr_re;
      bank_im[wr_idx] <= wr_im;
    end
  end

endmodule

// File: tb/tb_fft32_in_framer.sv
// Self-checking bench for fft32_in_framer: two instances (GAP=0 and GAP=5) driven with
// random traffic and compared each cycle against a frame-level reference model.
module tb_fft32_in_framer;

  localparam int NB = 16;

  typedef struct {
    logic [NB-1:0] re;
    logic [NB-1:0] im;
  } smp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;

  int mode = 0;
  int budget = 0;
  bit ramp = 1'b0;
  logic flush = 1'b0;
  int acc_cnt [2] = '{0, 0};
  int cur_idx [2] = '{-2, -2};
  int dut_starts [2] = '{0, 0};

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: observed %0h required %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int GP = (g == 0) ? 0 : 5;

    fft32_in_framer_if #(.nb(NB)) bus ();

    fft32_in_framer #(.nb(NB), .GAP(GP)) dut (
      .CLK (clk),
      .RST (rst_n),
      .bus (bus)
    );

`ifdef FRAMER_FLUSH_EN
    assign bus.FLUSH = flush;
`endif

    smp_t part [$];
    smp_t frames [$];
    int ready_at [$];
    bit active = 1'b0;
    int s_cyc = 0;
    int avail = 0;
    int mcyc = 0;
    bit rdy_en = 1'b0;
    bit exp_rdy = 1'b0;
    bit flushing = 1'b0;
    int flush_end = 0;
    int idx;
    logic drv_vld = 1'b0;
    logic [NB-1:0] drv_re = '0;
    logic [NB-1:0] drv_im = '0;
    smp_t exp_s;

    task automatic close_frame();
      for (int i = 0; i < 32; i++) frames.push_back(part[i]);
      part.delete();
      ready_at.push_back(mcyc + 1);
    endtask

    initial begin
      bus.IN_VLD = 1'b0;
      bus.IN_DR  = '0;
      bus.IN_DI  = '0;
    end

    always @(posedge clk) begin
      mcyc++;
      if (rst_n) begin
        if (drv_vld && exp_rdy) begin
          part.push_back('{drv_re, drv_im});
          acc_cnt[g]++;
          if (part.size() == 32) close_frame();
        end
`ifdef FRAMER_FLUSH_EN
        if (flushing && mcyc == flush_end) begin
          while (part.size() < 32) part.push_back('{'0, '0});
          close_frame();
          flushing = 1'b0;
        end else if (!flushing && flush && part.size() != 0) begin
          flushing = 1'b1;
          flush_end = mcyc + 32 - part.size();
        end
`endif
        rdy_en = 1'b1;
      end
    end

    always @(negedge clk) begin
      if (!rst_n) begin
        check_output($sformatf("g%0d_rst_start", g), bus.START, 0);
        check_output($sformatf("g%0d_rst_busy", g), bus.BUSY, 0);
        check_output($sformatf("g%0d_rst_dr", g), bus.DR, 0);
        check_output($sformatf("g%0d_rst_di", g), bus.DI, 0);
        check_output($sformatf("g%0d_rst_rdy", g), bus.IN_RDY, 0);
        part.delete();
        frames.delete();
        ready_at.delete();
        active = 1'b0;
        avail = 0;
        rdy_en = 1'b0;
        exp_rdy = 1'b0;
        flushing = 1'b0;
        cur_idx[g] = -2;
      end else begin
        exp_rdy = rdy_en && !flushing && (ready_at.size() < 2);
        if (!active && ready_at.size() > 0 && ready_at[0] <= mcyc && avail <= mcyc) begin
          active = 1'b1;
          s_cyc = mcyc;
        end
        idx = mcyc - s_cyc - 1;
        exp_s = '{'0, '0};
        if (active && idx >= 0) exp_s = frames[idx];
        if (bus.START === 1'b1) dut_starts[g]++;
        check_output($sformatf("g%0d_rdy", g), bus.IN_RDY, exp_rdy);
        check_output($sformatf("g%0d_start", g), bus.START, active && (idx < 0));
        check_output($sformatf("g%0d_busy", g), bus.BUSY, active);
        check_output($sformatf("g%0d_dr", g), bus.DR, exp_s.re);
        check_output($sformatf("g%0d_di", g), bus.DI, exp_s.im);
        cur_idx[g] = active ? idx : -2;
        if (active && idx == 31) begin
          for (int i = 0; i < 32; i++) void'(frames.pop_front());
          void'(ready_at.pop_front());
          active = 1'b0;
          avail = mcyc + 2 + GP;
        end
      end
      drv_vld = 1'b0;
      if (rst_n && acc_cnt[g] < budget) begin
        if (mode == 1) drv_vld = 1'b1;
        else if (mode == 2) drv_vld = ($urandom_range(0, 99) < 30);
      end
      drv_re = ramp ? NB'(acc_cnt[g]) : NB'($urandom);
      drv_im = ramp ? NB'(-acc_cnt[g]) : NB'($urandom);
      bus.IN_VLD = drv_vld;
      bus.IN_DR  = drv_re;
      bus.IN_DI  = drv_im;
    end
  end

  task automatic apply_stimulus(input int m, input int b, input bit r, input int cycles);
    @(negedge clk);
    #1;
    acc_cnt[0] = 0;
    acc_cnt[1] = 0;
    mode = m;
    budget = b;
    ramp = r;
    repeat (cycles) @(negedge clk);
    #1;
    mode = 0;
  endtask

  task automatic check_starts(input string tag, input int base0, input int base1, input int exp);
    check_output({tag, "_g0"}, dut_starts[0] - base0, exp);
    check_output({tag, "_g1"}, dut_starts[1] - base1, exp);
  endtask

  initial begin
    int b0, b1;
    bit hit;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    b0 = dut_starts[0]; b1 = dut_starts[1];
    apply_stimulus(1, 32, 1'b1, 90);
    check_starts("ramp_frame", b0, b1, 1);

    b0 = dut_starts[0]; b1 = dut_starts[1];
    apply_stimulus(1, 128, 1'b0, 280);
    check_starts("cont_4frames", b0, b1, 4);

    b0 = dut_starts[0]; b1 = dut_starts[1];
    apply_stimulus(2, 96, 1'b0, 560);
    check_starts("rand_30pct", b0, b1, 3);

    // Reset while sample 17 of a frame is on the output and the other bank fills
    @(negedge clk);
    #1;
    acc_cnt[0] = 0;
    acc_cnt[1] = 0;
    budget = 1000;
    ramp = 1'b0;
    mode = 1;
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      @(negedge clk);
      #2;
      if (cur_idx[0] == 17) hit = 1'b1;
    end
    check_output("trig_sample17", hit, 1);
    rst_n = 1'b0;
    mode = 0;
    #1;
    check_output("async_start", cfg[0].bus.START, 0);
    check_output("async_busy", cfg[0].bus.BUSY, 0);
    check_output("async_dr", cfg[0].bus.DR, 0);
    check_output("async_rdy", cfg[0].bus.IN_RDY, 0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    b0 = dut_starts[0]; b1 = dut_starts[1];
    apply_stimulus(1, 64, 1'b1, 150);
    check_starts("post_reset", b0, b1, 2);

    b0 = dut_starts[0]; b1 = dut_starts[1];
    apply_stimulus(1, 10, 1'b1, 20);
`ifdef FRAMER_FLUSH_EN
    flush = 1'b1;
    @(negedge clk);
    #1 flush = 1'b0;
    repeat (90) @(negedge clk);
    check_starts("flush_partial", b0, b1, 1);
`else
    repeat (90) @(negedge clk);
    check_starts("partial_holds", b0, b1, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
